twdl_seq_ctrl: RTL and testbench

- Sequencer that feeds per-vector twiddle configuration to the CTA twiddle-multiply stage of the mixed-radix (2/3/4/5) FFT.
- For each accepted 5-lane vector it presents the numerator, the stage denominator D, and the fractional turn (numerator·2^20)/D split into quotient and remainder.
- On start it computes the step constants 2^20/D once, using an iterative divider. Per-vector values are then updated incrementally, with no per-vector division.

---
 rtl/fft_cfg_pkg.sv | 30 +++
 rtl/twdl_recip_div.sv | 83 ++++++++
 rtl/twdl_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_twdl_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cfg_pkg.sv
// Shared FFT stage configuration types: radix codes, default widths, sequencer states.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package fft_cfg_pkg;

  // Default numerator/denominator width and fractional-turn resolution
  localparam int unsigned WNUM_DEFAULT = 12;
  localparam int unsigned WQUO_DEFAULT = 20;
  localparam int unsigned WVEC_DEFAULT = 16;

  // Stage radix code
  typedef logic [2:0] factor_t;
  localparam factor_t RDX2 = 3'd2;
  localparam factor_t RDX3 = 3'd3;
  localparam factor_t RDX4 = 3'd4;
  localparam factor_t RDX5 = 3'd5;

  // Twiddle sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

  // Only radix 2..5 stages exist in this FFT
  function automatic logic factor_legal(input factor_t f);
    return (f >= RDX2) && (f <= RDX5);
  endfunction

endpackage

// File: rtl/twdl_recip_div.sv
// Restoring divider of the fixed dividend 2^wQuo by D: qs = floor(2^wQuo/D), rs = 2^wQuo mod D.
// Latency: wQuo+1 cycles; the first quotient bit is resolved on the start edge, done pulses wQuo+1 cycles after start.
// Backpressure: none; start must only be issued while idle, results hold until the next start.
module twdl_recip_div
  import fft_cfg_pkg::*;
#(
  parameter int unsigned wNum = WNUM_DEFAULT,
  parameter int unsigned wQuo = WQUO_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [wNum-1:0] D,
  output logic            done,
  output logic [wQuo-1:0] qs,
  output logic [wNum-1:0] rs
);

  localparam int unsigned CW = $clog2(wQuo + 2);
  localparam logic [CW-1:0] ITERS = CW'(wQuo + 1);

  logic [wNum-1:0] d_q, d_d;
  logic [wNum-1:0] rem_q, rem_d;
  logic [wQuo-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            active;
  logic [CW-1:0]   cnt_use;
  logic [wNum-1:0] d_use;
  logic [wNum-1:0] rem_in;
  logic            div_bit;
  logic [wNum:0]   shifted;
  logic            ge;

  // One restoring step per cycle; the start cycle runs the first step with the fresh divisor
  always_comb begin
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    active  = start || (cnt_q != '0);
    cnt_use = start ? ITERS : cnt_q;
    d_use   = start ? D : d_q;
    rem_in  = start ? '0 : rem_q;
    // The dividend is a single one at bit wQuo, i.e. the first bit shifted in
    div_bit = (cnt_use == ITERS);
    shifted = {rem_in, div_bit};
    ge      = (shifted >= {1'b0, d_use});
    if (active) begin
      d_d    = d_use;
      // The partial remainder after subtraction is below D, so wNum-bit wrap arithmetic is exact
      rem_d  = ge ? (shifted[wNum-1:0] - d_use) : shifted[wNum-1:0];
      // Quotient bit wQuo is always 0 for D>=2 and falls off the top of the register
      quo_d  = start ? {{(wQuo-1){1'b0}}, ge} : {quo_q[wQuo-2:0], ge};
      cnt_d  = cnt_use - CW'(1);
      done_d = (cnt_use == CW'(1));
    end
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign qs   = quo_q;
  assign rs   = rem_q;

endmodule

// File: rtl/twdl_seq_ctrl.sv
// Twiddle sequencer: per accepted vector presents k, D and (k*2^wQuo)/D as quotient/remainder, updated incrementally.
// Latency: ready rises 22 cycles after an accepted start; each accepted vector advances outputs on the next edge.
// Backpressure: none; in_val outside RUN is dropped and flagged on the sticky ovf.
module twdl_seq_ctrl
  import fft_cfg_pkg::*;
#(
  parameter int unsigned wNum = WNUM_DEFAULT,
  parameter int unsigned wQuo = WQUO_DEFAULT,
  parameter int unsigned wVec = WVEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      cfg_factor,
  input  logic [wNum-1:0] cfg_demontr,
  input  logic [wVec-1:0] cfg_nvec,
  input  logic            in_val,
  output logic            busy,
  output logic            ready,
  output logic [2:0]      factor,
  output logic [wNum-1:0] twdl_numrtr_1,
  output logic [wNum-1:0] twdl_demontr,
  output logic [wQuo-1:0] twdl_quotient,
  output logic [wNum-1:0] twdl_remainder,
  output logic            twdl_val,
  output logic            done,
  output logic            cfg_err,
  output logic            ovf
);

  ctrl_state_t     state_q, state_d;
  factor_t         factor_q, factor_d;
  logic [wNum-1:0] d_q, d_d;
  logic [wVec-1:0] nvec_q, nvec_d;
  logic [wNum-1:0] k_q, k_d;
  logic [wQuo-1:0] q_q, q_d;
  logic [wNum-1:0] r_q, r_d;
  logic [wVec-1:0] vcnt_q, vcnt_d;
  logic            tv_q, tv_d;
  logic            done_q, done_d;
  logic            cfg_err_q, cfg_err_d;
  logic            ovf_q, ovf_d;

  logic            cfg_ok;
  logic            div_start;
  logic            div_done;
  logic [wQuo-1:0] qs;
  logic [wNum-1:0] rs;
  logic [wVec-1:0] vcnt_inc;
  logic [wNum:0]   s;
  logic            s_ge;

  twdl_recip_div #(
    .wNum (wNum),
    .wQuo (wQuo)
  ) u_recip_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .D     (cfg_demontr),
    .done  (div_done),
    .qs    (qs),
    .rs    (rs)
  );

  // Next-state and datapath: config latch, divider launch, incremental k/q/r stepping
  always_comb begin
    state_d   = state_q;
    factor_d  = factor_q;
    d_d       = d_q;
    nvec_d    = nvec_q;
    k_d       = k_q;
    q_d       = q_q;
    r_d       = r_q;
    vcnt_d    = vcnt_q;
    tv_d      = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    ovf_d     = ovf_q;
    div_start = 1'b0;
    cfg_ok    = (cfg_demontr >= wNum'(2)) && factor_legal(cfg_factor) && (cfg_nvec != '0);
    vcnt_inc  = vcnt_q + wVec'(1);
    // r < D and rs < D, so one conditional subtraction restores r < D
    s         = {1'b0, r_q} + {1'b0, rs};
    s_ge      = (s >= {1'b0, d_q});

    case (state_q)
      IDLE: begin
        k_d    = '0;
        q_d    = '0;
        r_d    = '0;
        vcnt_d = '0;
        if (start) begin
          if (cfg_ok) begin
            factor_d  = cfg_factor;
            d_d       = cfg_demontr;
            nvec_d    = cfg_nvec;
            ovf_d     = 1'b0;
            div_start = 1'b1;
            state_d   = DIV;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DIV: begin
        k_d    = '0;
        q_d    = '0;
        r_d    = '0;
        vcnt_d = '0;
        if (div_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_val) begin
          tv_d   = 1'b1;
          vcnt_d = vcnt_inc;
          if (k_q == d_q - wNum'(1)) begin
            k_d = '0;
            q_d = '0;
            r_d = '0;
          end else begin
            k_d = k_q + wNum'(1);
            r_d = s_ge ? (s[wNum-1:0] - d_q) : s[wNum-1:0];
            q_d = q_q + qs + {{(wQuo-1){1'b0}}, s_ge};
          end
          if (vcnt_inc == nvec_q) begin
            // Frame complete: outputs return to the idle clamp values
            state_d = IDLE;
            done_d  = 1'b1;
            k_d     = '0;
            q_d     = '0;
            r_d     = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Vectors arriving outside RUN are dropped but remembered
    if (in_val && (state_q != RUN)) begin
      ovf_d = 1'b1;
    end
  end

  // Sequencer state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      factor_q  <= '0;
      d_q       <= '0;
      nvec_q    <= '0;
      k_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      vcnt_q    <= '0;
      tv_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      factor_q  <= factor_d;
      d_q       <= d_d;
      nvec_q    <= nvec_d;
      k_q       <= k_d;
      q_q       <= q_d;
      r_q       <= r_d;
      vcnt_q    <= vcnt_d;
      tv_q      <= tv_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy           = (state_q == DIV) || (state_q == RUN);
  assign ready          = (state_q == RUN);
  assign factor         = factor_q;
  assign twdl_numrtr_1  = k_q;
  assign twdl_demontr   = d_q;
  assign twdl_quotient  = q_q;
  assign twdl_remainder = r_q;
  assign twdl_val       = tv_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_twdl_seq_ctrl.sv
// Randomized scoreboard bench for twdl_seq_ctrl against a closed-form twiddle model.
// Latency: checks ready 22 cycles after start and done one cycle after the last vector.
// Backpressure: drives in_val with random gaps and out-of-RUN vectors.
module tb_twdl_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_factor;
  logic [11:0] cfg_demontr;
  logic [15:0] cfg_nvec;
  logic        in_val;
  logic        busy, ready;
  logic [2:0]  factor;
  logic [11:0] twdl_numrtr_1, twdl_demontr, twdl_remainder;
  logic [19:0] twdl_quotient;
  logic        twdl_val, done, cfg_err, ovf;

  typedef struct {
    longint k;
    longint q;
    longint r;
    longint d;
    longint f;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad = 0;
  int     done_seen = 0;
  int     exp_done = 0;
  logic   drv_acc = 1'b0;
  logic   prev_acc = 1'b0;
  logic   mon_en = 1'b0;

  always #5 clk = ~clk;

  twdl_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_factor     (cfg_factor),
    .cfg_demontr    (cfg_demontr),
    .cfg_nvec       (cfg_nvec),
    .in_val         (in_val),
    .busy           (busy),
    .ready          (ready),
    .factor         (factor),
    .twdl_numrtr_1  (twdl_numrtr_1),
    .twdl_demontr   (twdl_demontr),
    .twdl_quotient  (twdl_quotient),
    .twdl_remainder (twdl_remainder),
    .twdl_val       (twdl_val),
    .done           (done),
    .cfg_err        (cfg_err),
    .ovf            (ovf)
  );

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Vector j of a frame: k = j mod D, and k/D of a turn expressed in 2^20 units
  function automatic exp_t model(input int f, input int d, input int j);
    exp_t e;
    longint num;
    e.k = longint'(j % d);
    num = e.k * 1048576;
    e.q = num / longint'(d);
    e.r = num % longint'(d);
    e.d = longint'(d);
    e.f = longint'(f);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_ready"}, longint'(ready), 0);
    chk({tag, "_factor"}, longint'(factor), 0);
    chk({tag, "_numrtr"}, longint'(twdl_numrtr_1), 0);
    chk({tag, "_demontr"}, longint'(twdl_demontr), 0);
    chk({tag, "_quotient"}, longint'(twdl_quotient), 0);
    chk({tag, "_remainder"}, longint'(twdl_remainder), 0);
    chk({tag, "_twdl_val"}, longint'(twdl_val), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_cfg_err"}, longint'(cfg_err), 0);
    chk({tag, "_ovf"}, longint'(ovf), 0);
  endtask

  task automatic bad_start(input int f, input int d, input int n);
    cfg_factor = 3'(f);
    cfg_demontr = 12'(d);
    cfg_nvec = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", longint'(cfg_err), 1);
    chk("cfg_err_busy", longint'(busy), 0);
    tick();
    chk("cfg_err_clear", longint'(cfg_err), 0);
    chk("cfg_err_busy2", longint'(busy), 0);
  endtask

  // gap < 0: random 0..2 idle cycles between vectors; rst_at >= 0: reset instead of that vector
  task automatic run_frame(input int f, input int d, input int n, input int gap,
                           input bit noise, input int rst_at, input bit ign_start);
    int cyc;
    exp_t e;
    cfg_factor = 3'(f);
    cfg_demontr = 12'(d);
    cfg_nvec = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", longint'(busy), 1);
    chk("start_ovf_clear", longint'(ovf), 0);
    cyc = 1;
    while (!ready && cyc < 100) begin
      in_val = noise && (cyc == 3);
      drv_acc = 1'b0;
      tick();
      cyc++;
      if (noise && cyc == 4) begin
        chk("div_ovf", longint'(ovf), 1);
        chk("div_twdl_val", longint'(twdl_val), 0);
      end
    end
    in_val = 1'b0;
    chk("ready_latency", longint'(cyc), 22);
    if (!ready) return;
    for (int j = 0; j < n; j++) begin
      int g;
      g = (j == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
      for (int i = 0; i < g; i++) begin
        in_val = 1'b0;
        drv_acc = 1'b0;
        tick();
        e = model(f, d, j);
        chk("hold_k", longint'(twdl_numrtr_1), e.k);
        chk("hold_q", longint'(twdl_quotient), e.q);
        chk("hold_r", longint'(twdl_remainder), e.r);
      end
      if (j == rst_at) begin
        rst = 1'b1;
        in_val = 1'b1;
        drv_acc = 1'b0;
        tick();
        rst = 1'b0;
        in_val = 1'b0;
        check_zero("rst_run");
        return;
      end
      exp_q.push_back(model(f, d, j));
      in_val = 1'b1;
      drv_acc = 1'b1;
      if (ign_start && j == 1) begin
        start = 1'b1;
        cfg_demontr = 12'd1;
      end
      tick();
      if (ign_start && j == 1) begin
        start = 1'b0;
        chk("start_in_run_no_err", longint'(cfg_err), 0);
        if (n > 2) chk("start_in_run_busy", longint'(busy), 1);
      end
    end
    in_val = 1'b0;
    drv_acc = 1'b0;
    exp_done++;
    chk("frame_done", longint'(done), 1);
    chk("frame_last_val", longint'(twdl_val), 1);
    chk("frame_ready_low", longint'(ready), 0);
    chk("frame_busy_low", longint'(busy), 0);
    tick();
    chk("done_once", longint'(done), 0);
    chk("idle_k", longint'(twdl_numrtr_1), 0);
    chk("idle_q", longint'(twdl_quotient), 0);
    chk("idle_r", longint'(twdl_remainder), 0);
    chk("idle_demontr", longint'(twdl_demontr), longint'(d));
    chk("idle_factor", longint'(factor), longint'(f));
  endtask

  // Monitor: pops the scoreboard whenever the DUT consumes a vector, and tracks twdl_val/done
  always @(negedge clk) begin
    if (mon_en) begin
      chk("twdl_val", longint'(twdl_val), longint'(prev_acc));
      if (!rst && ready && in_val) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vec_k", longint'(twdl_numrtr_1), mon_e.k);
          chk("vec_q", longint'(twdl_quotient), mon_e.q);
          chk("vec_r", longint'(twdl_remainder), mon_e.r);
          chk("vec_d", longint'(twdl_demontr), mon_e.d);
          chk("vec_factor", longint'(factor), mon_e.f);
        end
      end
      if (done) done_seen++;
    end
    prev_acc = drv_acc && !rst;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_factor = '0;
    cfg_demontr = '0;
    cfg_nvec = '0;
    in_val = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    run_frame(2, 5, 7, 0, 1'b0, -1, 1'b0);
    run_frame(3, 3, 4, 0, 1'b0, -1, 1'b0);
    run_frame(5, 4095, 4096, 0, 1'b0, -1, 1'b0);
    run_frame(4, 4, 2, 2, 1'b0, -1, 1'b0);

    bad_start(2, 1, 3);
    bad_start(7, 5, 3);
    bad_start(2, 5, 0);

    run_frame(2, 6, 5, 0, 1'b1, -1, 1'b0);
    chk("ovf_sticky", longint'(ovf), 1);
    run_frame(3, 7, 3, -1, 1'b0, -1, 1'b0);

    run_frame(2, 5, 7, 0, 1'b0, 2, 1'b0);
    tick();
    run_frame(2, 5, 7, 0, 1'b0, -1, 1'b0);

    run_frame(5, 9, 12, -1, 1'b0, -1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      int d;
      d = int'($urandom_range(2, 40));
      run_frame(int'($urandom_range(2, 5)), d, int'($urandom_range(1, 2 * d + 3)), -1,
                1'b0, -1, 1'b0);
      tick();
    end

    tick();
    tick();
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    chk("done_count", longint'(done_seen), longint'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
